// File: rtl/uart_pkg.sv
// uart_pkg: shared control-register bit indices, frame state encoding and defaults
//    CTRL_SEND_BIT / CTRL_NEW_RX_BIT : bit positions in the 32-bit control register
//    frame_state_e                   : frame sequencer states (PARITY used only with UART_PARITY_EN)
//    DEFAULT_BAUD_DIV                : 10 MHz / 9600 baud, rounded
package uart_pkg;
   localparam int CTRL_SEND_BIT    = 0;
   localparam int CTRL_NEW_RX_BIT  = 1;
   localparam int DEFAULT_BAUD_DIV = 1042;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } frame_state_e;
   function automatic logic [31:0] clear_send(input logic [31:0] ctrl);
      return ctrl & ~(32'd1 << CTRL_SEND_BIT);
   endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter producing a one-cycle bit_done tick
//    clk_i      : clock
//    rst_i      : synchronous active-high reset, clears the count
//    load_i     : load load_val_i (takes priority over counting)
//    load_val_i : reload value, one less than the cycles per bit
//    en_i       : count enable; also qualifies the tick
//    bit_done_o : high for the cycle in which an enabled count sits at zero
module uart_baud_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             bit_done_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign bit_done_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: serializes the TX data byte when SEND is set, then clears SEND by read-modify-write
//    clk_i       : system clock
//    rst_i       : synchronous active-high reset
//    ctrl_i      : control register value (bit0 SEND, bit1 NEW_RX)
//    data_i      : TX data register, low DATA_W bits are sent
//    ctrl_wr_o   : one-cycle write strobe into the control register
//    ctrl_data_o : write-back value, ctrl_i with SEND cleared
//    tx_o        : serial line, idle high
//    busy_o      : frame in progress
// Build option: UART_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
   parameter int DATA_W   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ctrl_i,
   input  logic [31:0] data_i,
   output logic        ctrl_wr_o,
   output logic [31:0] ctrl_data_o,
   output logic        tx_o,
   output logic        busy_o
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_DATA  = ST_DATA;
   localparam logic [2:0] S_STOP  = ST_STOP;
   localparam logic [2:0] S_DONE  = ST_DONE;
`ifdef UART_PARITY_EN
   localparam logic [2:0] S_PARITY     = ST_PARITY;
   localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
   localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif
   logic [2:0]        state_q, state_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              tx_q, tx_d, busy_q, wr_q;
   logic [31:0]       wdata_q;
   logic              start, in_bit, bit_done;
   logic              unused_data;
   assign unused_data = ^(data_i >> DATA_W);
   // The write-back lands in the register one edge after wr_q rises, so IDLE
   // must not act on the stale SEND it still sees during that cycle.
   assign start  = (state_q == S_IDLE) && ctrl_i[CTRL_SEND_BIT] && !wr_q;
   assign in_bit = (state_q != S_IDLE) && (state_q != S_DONE);
   uart_baud_cnt #(.CNT_W(16)) u_baud (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (start || bit_done),
      .load_val_i (RELOAD),
      .en_i       (in_bit),
      .bit_done_o (bit_done)
   );
`ifdef UART_PARITY_EN
   logic par_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) par_q <= 1'b0;
      else if (start) par_q <= ^data_i[DATA_W-1:0];
   end
`endif
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_START;
               sh_d    = data_i[DATA_W-1:0];
            end
         end
         S_START: state_d = bit_done ? S_DATA : state_q;
         S_DATA: begin
            if (bit_done) begin
               sh_d    = sh_q >> 1;
               bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
               state_d = (bit_q == LAST_BIT) ? S_AFTER_DATA : state_q;
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: state_d = bit_done ? S_STOP : state_q;
`endif
         S_STOP: state_d = bit_done ? S_DONE : state_q;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // Line level follows the state one edge later, giving the registered
   // one-cycle latency from SEND to the start bit.
   always_comb tx_d = (state_q == S_START) ? 1'b0 :
                      (state_q == S_DATA)  ? sh_q[0] :
`ifdef UART_PARITY_EN
                      (state_q == S_PARITY) ? par_q :
`endif
                      1'b1;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= state_q != S_IDLE;
         wr_q    <= state_q == S_DONE;
         if (state_q == S_DONE) wdata_q <= clear_send(ctrl_i);
      end
   end
   assign tx_o        = tx_q;
   assign busy_o      = busy_q;
   assign ctrl_wr_o   = wr_q;
   assign ctrl_data_o = wdata_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl with a modelled control register
module tb_uart_tx_ctrl;
   localparam int BAUD = 4;
`ifdef UART_PARITY_EN
   localparam int NB  = 11;
   localparam int LAT = 45;
`else
   localparam int NB  = 10;
   localparam int LAT = 41;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ctrl = '0;
   logic [31:0] data = '0;
   logic [31:0] user_val = '0;
   logic        user_wr = 1'b0;
   logic        ctrl_wr, tx, busy;
   logic [31:0] ctrl_wdata;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        mon_off = 1'b0;
   int          wb_t_q[$];
   logic [31:0] wb_d_q[$];
   logic [NB-1:0] rx_q[$];

   uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ctrl_i      (ctrl),
      .data_i      (data),
      .ctrl_wr_o   (ctrl_wr),
      .ctrl_data_o (ctrl_wdata),
      .tx_o        (tx),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Register file: user write port wins over the interface write-back.
   always @(posedge clk) ctrl <= user_wr ? user_val : ctrl_wr ? ctrl_wdata : ctrl;

   function automatic logic [NB-1:0] frame(input logic [7:0] b);
      logic [NB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic user_write(input logic [31:0] v);
      user_wr = 1'b1;
      user_val = v;
      tick(1);
      user_wr = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic [31:0] cv, input logic [31:0] wb,
                       input bit expect_out, output int t);
      data = {24'h0, b};
      t = cyc + 2;
      if (expect_out) begin
         rx_q.push_back(frame(b));
         wb_t_q.push_back(t);
         wb_d_q.push_back(wb);
      end
      user_write(cv);
   endtask

   always @(negedge clk) begin : wr_mon
      int t;
      logic [31:0] d;
      if (ctrl_wr === 1'b1) begin
         if (wb_t_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wb_unexpected: got ctrl_wr=1 data %h expected no write (cycle %0d)", ctrl_wdata, cyc);
         end else begin
            t = wb_t_q.pop_front();
            d = wb_d_q.pop_front();
            check("wb_data", ctrl_wdata, d);
            check("wb_latency", cyc - t, LAT);
         end
      end
   end

   initial begin : rx_mon
      logic prev;
      logic [NB-1:0] got, exp;
      logic stable;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!mon_off && prev === 1'b1 && tx === 1'b0) begin
            stable = 1'b1;
            got = '0;
            for (int b = 0; b < NB; b++)
               for (int c = 0; c < BAUD; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (c == 0) got[b] = tx;
                  else if (tx !== got[b]) stable = 1'b0;
               end
            vectors++;
            if (rx_q.size() == 0) begin
               miscompares++;
               $display("FAIL rx_unexpected: got frame %b expected none", got);
            end else begin
               exp = rx_q.pop_front();
               if (got !== exp || !stable) begin
                  miscompares++;
                  $display("FAIL rx_frame: got %b (stable=%0d) expected %b", got, stable, exp);
               end
            end
         end
         prev = tx;
      end
   end

   initial begin : stim
      int t;
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_outputs", {29'h0, tx, busy, ctrl_wr}, 32'h4);
      end
      tick(1);
      send(8'hA5, 32'h1, 32'h0, 1'b1, t);
      tick(3);
      check("busy_in_frame", {31'h0, busy}, 32'h1);
      tick(LAT + 1);
      check("no_retrigger", {31'h0, busy}, 32'h0);
      check("send_cleared", ctrl, 32'h0);
      send(8'h3C, 32'h3, 32'h2, 1'b1, t);
      tick(LAT + 4);
      check("new_rx_kept", ctrl, 32'h2);
      send(8'h07, 32'h1, 32'h0, 1'b1, t);
      tick(LAT + 4);
      send(8'h55, 32'h1, 32'h0, 1'b1, t);
      tick(6);
      data = 32'hFF;
      tick(LAT - 2);
      send(8'h81, 32'h1, 32'h4, 1'b1, t);
      tick(9);
      user_write(32'h4);
      tick(LAT - 6);
      check("send_cleared_midframe", ctrl, 32'h4);
      send(8'hC3, 32'h1, 32'h0, 1'b1, t);
      tick(42);
      rx_q.push_back(frame(8'hC3));
      wb_t_q.push_back(t + 43);
      wb_d_q.push_back(32'h0);
      user_write(32'h1);
      tick(LAT + 6);
      check("collision_final_ctrl", ctrl, 32'h0);
      check("collision_idle", {31'h0, busy}, 32'h0);
      mon_off = 1'b1;
      send(8'h0F, 32'h1, 32'h0, 1'b0, t);
      tick(18);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_outputs", {29'h0, tx, busy, ctrl_wr}, 32'h4);
      check("rst_send_kept", ctrl, 32'h1);
      rx_q.push_back(frame(8'h0F));
      wb_t_q.push_back(t + 19);
      wb_d_q.push_back(32'h0);
      mon_off = 1'b0;
      tick(LAT + 6);
      check("rx_queue_empty", rx_q.size(), 32'h0);
      check("wb_queue_empty", wb_t_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Interface-side consumer of the UART 32-bit control register.
- Watches the SEND bit written by the user. Latches the byte from the TX data register and serializes it as an 8N1 frame on the tx line.
- On completion, writes the control register back through the interface write port (write-enable 2 / data-in 2) with SEND cleared and all other bits preserved.
- Sits between the register file and the UART pin.

Parameters:
- BAUD_DIV, 1042, clock cycles per bit (10 MHz / 9600 baud, rounded); legal range 2..65535.
- DATA_W, 8, payload bits per frame.

Ports:
- clk_i  in  1  system clock, 10 MHz
- rst_i  in  1  synchronous reset, active-high
- ctrl_i  in  32  current control register value; bit0 = SEND, bit1 = NEW_RX, others reserved
- data_i  in  32  TX data register; bits [DATA_W-1:0] are sent
- ctrl_wr_o  out  1  interface write enable into the control register (wr2 side)
- ctrl_data_o  out  32  interface write data into the control register
- tx_o  out  1  serial line, idle high
- busy_o  out  1  high while a frame is in progress (START through DONE)

Behaviour:
- Reset values:
  - Synchronous reset, active-high.
  - tx_o=1, busy_o=0, ctrl_wr_o=0, ctrl_data_o=0.
  - State IDLE; bit counter and baud counter cleared.
- All outputs are registered.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - tx_o=1.
  - If ctrl_i[0]==1 at an edge: latch data_i[DATA_W-1:0] into the shift register, load the baud counter, and go to START.
  - tx_o falls on the following cycle (1-cycle latency from SEND seen).
- START: tx_o=0 for BAUD_DIV cycles, then DATA.
- DATA:
  - DATA_W bits, LSB first, each held BAUD_DIV cycles.
  - Bit counter wraps DATA_W-1 -> 0 on exit to STOP.
- STOP: tx_o=1 for BAUD_DIV cycles, then DONE.
- DONE:
  - Exactly one cycle with ctrl_wr_o=1 and ctrl_data_o = ctrl_i with bit0 forced to 0.
  - Read-modify-write, sampled that cycle, so NEW_RX and the reserved bits are preserved.
  - Then go to IDLE.
- Frame timing: the start bit begins at cycle t+1; ctrl_wr_o pulses at cycle t+1+(DATA_W+2)*BAUD_DIV.
- ctrl_wr_o is 0 in every state except DONE. ctrl_data_o holds its last value otherwise.
- The baud counter is 16 bits, counting BAUD_DIV-1 down to 0; a bit advances when it reaches 0.
- Boundary conditions:
  - data_i changes during a frame: ignored; only the latched byte is sent.
  - SEND cleared by the user mid-frame: the frame completes and the write-back still occurs (SEND written 0 again).
  - User write (wr1) in the same cycle as the DONE write: the user value wins in the register. If SEND stays 1, the next IDLE cycle starts a new frame.
  - Back-to-back frames: IDLE lasts at least 1 cycle after DONE. ctrl_i reflects the cleared SEND by then, so no false retrigger.
  - Reset mid-frame: tx_o returns to 1 on the next edge, no write-back occurs, and SEND remains as the register holds it.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It sends the even-parity bit (XOR of the latched byte) for BAUD_DIV cycles.
  - The frame becomes DATA_W+3 bits, so the write-back pulse moves to t+1+(DATA_W+3)*BAUD_DIV.
- When undefined: no PARITY state, pure 8N1.

Decomposition:
- Shared package uart_pkg:
  - Control bit indices: CTRL_SEND_BIT=0, CTRL_NEW_RX_BIT=1.
  - Frame state enum: IDLE, START, DATA, PARITY, STOP, DONE.
  - Default BAUD_DIV constant, 1042.
- Sub-module uart_baud_cnt:
  - Loadable down-counter; outputs a one-cycle bit_done tick.
  - Reusable by the future receiver at half-bit offset.

Test Plan:
- Reset then idle, BAUD_DIV=4:
  - Stimulus: rst_i for 2 cycles, ctrl_i=0.
  - Response: tx_o=1, busy_o=0, ctrl_wr_o=0 for 50 cycles.
- Single frame, BAUD_DIV=4:
  - Stimulus: data_i=0x0000_00A5, ctrl_i=0x1.
  - Response: tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. ctrl_wr_o pulses once, 41 cycles after SEND sampled, with ctrl_data_o=0x0.
- Bit preservation:
  - Stimulus: ctrl_i=0x0000_0003 during the frame.
  - Response: write-back ctrl_data_o=0x0000_0002.
- Mid-frame data change:
  - Stimulus: data_i switches 0x55 -> 0xFF after the start bit.
  - Response: the serialized payload is still 0x55.
- Reset mid-frame:
  - Stimulus: rst_i asserted during data bit 3.
  - Response: tx_o=1 on the next cycle, busy_o=0, no ctrl_wr_o pulse.
- UART_PARITY_EN defined, BAUD_DIV=4:
  - Stimulus: data_i=0x07.
  - Response: parity bit 1 after data bits; write-back pulse 45 cycles after SEND sampled.
